// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the 8-digit seven-segment scan controller:
// register addresses, digit count, blank pattern and anode helper.
package seg7_scan_ctrl_pkg;

  localparam logic [1:0] SEG7_ADDR_LO    = 2'b00;
  localparam logic [1:0] SEG7_ADDR_HI    = 2'b10;
  localparam logic [1:0] SEG7_ADDR_MASK  = 2'b01;
  localparam logic [1:0] SEG7_ADDR_BLINK = 2'b11;

  localparam int unsigned SEG7_DIGITS  = 8;
  localparam int unsigned SEG7_IDX_W   = $clog2(SEG7_DIGITS);
  localparam int unsigned SEG7_SEG_W   = 7;
  localparam logic [7:0]  SEG7_ALL_OFF = 8'hFF;

  // Active-low one-hot anode pattern for a digit slot.
  function automatic logic [SEG7_DIGITS-1:0] seg7_anode(input logic [SEG7_IDX_W-1:0] idx);
    return ~(SEG7_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Nibble to active-low g..a segment pattern, purely combinational.
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0]            nibble,
  output logic [SEG7_SEG_W-1:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 8-digit common-anode seven-segment scan controller.
// Optional blink support is built when SEG7_BLINK_EN is defined.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 23000
`ifdef SEG7_BLINK_EN
  ,
  parameter int unsigned BLINK_DIV   = 5750000
`endif
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        segcs,
  input  logic        segwrite,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [31:0]            value;
  logic [7:0]             en_mask;
  logic [7:0]             dp_mask;
  logic [CNT_W-1:0]       cnt;
  logic [SEG7_IDX_W-1:0]  idx;

  logic                   wr_en_c;
  logic                   cnt_last_c;
  logic                   blink_off_c;
  logic                   blank_c;
  logic [3:0]             nibble_c;
  logic [SEG7_SEG_W-1:0]  hex_c;
  logic [7:0]             an_nxt_c;
  logic [7:0]             out_nxt_c;

  assign wr_en_c    = segcs & segwrite;
  assign cnt_last_c = (cnt == CNT_W'(REFRESH_DIV - 1));

  // Software-visible display registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      value   <= '0;
      en_mask <= 8'hFF;
      dp_mask <= '0;
    end else if (wr_en_c) begin
      case (segaddr)
        SEG7_ADDR_LO:   value[15:0]        <= segwdata;
        SEG7_ADDR_HI:   value[31:16]       <= segwdata;
        SEG7_ADDR_MASK: {dp_mask, en_mask} <= segwdata;
        default: ;
      endcase
    end
  end

  // Refresh counter and digit slot index; writes never touch these.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last_c) begin
      cnt <= '0;
      idx <= idx + SEG7_IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BCNT_W = $clog2(BLINK_DIV);

  logic [7:0]        blink_mask;
  logic [BCNT_W-1:0] bcnt;
  logic              blink_phase;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      blink_mask <= '0;
    end else if (wr_en_c && (segaddr == SEG7_ADDR_BLINK)) begin
      blink_mask <= segwdata[7:0];
    end
  end

  // Free-running blink timebase; phase flips every BLINK_DIV cycles.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      bcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (bcnt == BCNT_W'(BLINK_DIV - 1)) begin
      bcnt        <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      bcnt <= bcnt + BCNT_W'(1);
    end
  end

  assign blink_off_c = blink_phase & blink_mask[idx];
`else
  assign blink_off_c = 1'b0;
`endif

  assign nibble_c = value[{idx, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nibble (nibble_c),
    .seg    (hex_c)
  );

  // First cycle of each slot is blanked to avoid ghosting between digits.
  always_comb begin
    blank_c   = (cnt == '0) | ~en_mask[idx] | blink_off_c;
    an_nxt_c  = SEG7_ALL_OFF;
    out_nxt_c = SEG7_ALL_OFF;
    if (!blank_c) begin
      an_nxt_c  = seg7_anode(idx);
      out_nxt_c = {~dp_mask[idx], hex_c};
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      seg_an  <= SEG7_ALL_OFF;
      seg_out <= SEG7_ALL_OFF;
    end else begin
      seg_an  <= an_nxt_c;
      seg_out <= out_nxt_c;
    end
  end

endmodule
